// File: rtl/ahb_arbiter.sv
// Four-master AHB bus arbiter: round-robin grant with burst and locked-transfer hold.
// Grant, owner and lock state advance only when hready completes a transfer phase.
module ahb_arbiter #(
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic [3:0] hbusreq,
  input  logic [3:0] hlock,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  input  logic       hready,
  input  logic       hresp,
  output logic [3:0] hgrant,
  output logic [1:0] hmaster,
  output logic       hmastlock
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  localparam logic [1:0] DEF_IDX   = DEFAULT_MASTER[1:0];
  localparam logic [3:0] DEF_GRANT = 4'b0001 << DEF_IDX;

  logic [3:0] cnt_r;
  logic [1:0] last_r;
  logic [3:0] cnt_nxt_s;
  logic [1:0] gidx_s;
  logic [2:0] pick_s;
  logic [1:0] state_s;
  logic [3:0] grant_nxt_s;
  logic [1:0] last_nxt_s;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Walk from lowest to highest priority so the nearest requester after last wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  assign gidx_s = onehot_to_idx(hgrant);
  assign pick_s = rr_pick(hbusreq, last_r);

  // Beat counter next value; an ERROR response ends the burst even during a stall.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (hresp) begin
      cnt_nxt_s = 4'd0;
    end else if (hready) begin
      case (htrans)
        HTRANS_NONSEQ: begin
          case (hburst)
            3'd2, 3'd3: cnt_nxt_s = 4'd3;
            3'd4, 3'd5: cnt_nxt_s = 4'd7;
            3'd6, 3'd7: cnt_nxt_s = 4'd15;
            default:    cnt_nxt_s = 4'd0;
          endcase
        end
        HTRANS_SEQ: begin
          if (cnt_r != 4'd0) begin
            cnt_nxt_s = cnt_r - 4'd1;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        HTRANS_IDLE: cnt_nxt_s = 4'd0;
        HTRANS_BUSY: cnt_nxt_s = cnt_r;
        default:     cnt_nxt_s = cnt_r;
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Hold classification: a lock outranks an unfinished burst.
  always_comb begin
    state_s = ST_ARB;
    if (hlock[gidx_s]) begin
      state_s = ST_LOCK;
    end else if (cnt_nxt_s != 4'd0) begin
      state_s = ST_BURST;
    end else begin
      state_s = ST_ARB;
    end
  end

  // Grant selection; parking on the default master leaves the round-robin pointer alone.
  always_comb begin
    grant_nxt_s = hgrant;
    last_nxt_s  = last_r;
    if (state_s == ST_ARB) begin
      if (pick_s[2]) begin
        grant_nxt_s = 4'b0001 << pick_s[1:0];
        last_nxt_s  = pick_s[1:0];
      end else begin
        grant_nxt_s = DEF_GRANT;
        last_nxt_s  = last_r;
      end
    end else begin
      grant_nxt_s = hgrant;
      last_nxt_s  = last_r;
    end
  end

  // State registers: owner follows the grant one accepted edge later.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      hgrant    <= DEF_GRANT;
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
      cnt_r     <= 4'd0;
      last_r    <= 2'd3;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (hready) begin
        hgrant    <= grant_nxt_s;
        last_r    <= last_nxt_s;
        hmaster   <= gidx_s;
        hmastlock <= hlock[gidx_s];
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: a transaction-level model predicts each edge's
// outputs into a queue, and an independent monitor pops and compares every cycle.
module tb_ahb_arbiter;

  localparam int DEF = 0;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic       hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0] exp_q[$];

  // Reference model state: granted index, round-robin pointer, beats left, owner, lock.
  int   m_g;
  int   m_last;
  int   m_beats;
  int   m_mst;
  logic m_ml;
  int   beats_of_burst[8] = '{0, 0, 3, 3, 7, 7, 15, 15};

  ahb_arbiter #(.DEFAULT_MASTER(DEF)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready), .hresp(hresp),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  always #5 hclk = ~hclk;

  function automatic void model_step();
    int nb;
    int found;
    if (!hresetn) begin
      m_g = DEF; m_mst = DEF; m_ml = 1'b0; m_beats = 0; m_last = 3;
      return;
    end
    nb = m_beats;
    if (hresp) nb = 0;
    else if (hready) begin
      if (htrans == 2'b10) nb = beats_of_burst[hburst];
      else if (htrans == 2'b11) nb = (m_beats > 0) ? m_beats - 1 : m_beats;
      else if (htrans == 2'b00) nb = 0;
    end
    if (hready) begin
      m_mst = m_g;
      m_ml  = hlock[m_g];
      if (nb == 0 && !hlock[m_g]) begin
        found = -1;
        for (int k = 1; k <= 4; k++)
          if (found < 0 && hbusreq[(m_last + k) % 4]) found = (m_last + k) % 4;
        if (found >= 0) begin
          m_g = found; m_last = found;
        end else begin
          m_g = DEF;
        end
      end
    end
    m_beats = nb;
  endfunction

  task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] lk,
                       input logic [1:0] tr, input logic [2:0] bu, input logic rdy,
                       input logic rsp);
    logic [3:0] g1h;
    hresetn = rst; hbusreq = req; hlock = lk; htrans = tr; hburst = bu;
    hready = rdy; hresp = rsp;
    model_step();
    g1h = 4'b0001 << m_g;
    exp_q.push_back({g1h, 2'(m_mst), m_ml});
    @(posedge hclk);
    @(negedge hclk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: outputs settle one step after every rising edge.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge hclk);
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: got %b expected a queued entry", {hgrant, hmaster, hmastlock});
      end else begin
        e = exp_q.pop_front();
        if ({hgrant, hmaster, hmastlock} !== e)begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got grant=%b mst=%0d lock=%b expected grant=%b mst=%0d lock=%b",
                   $time, hgrant, hmaster, hmastlock, e[6:3], e[2:1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [3:0] rr_seq [5];
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    drive(1'b0, 4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1, 1'b0);
    check("reset_grant", 32'(hgrant), 32'h1);
    check("reset_master", 32'(hmaster), 32'h0);

    // Round robin with all masters requesting single transfers.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 1'b0);
      check("rr_grant", 32'(hgrant), 32'(rr_seq[i]));
    end
    check("rr_master_trails", 32'(hmaster), 32'h3);

    // INCR4 owned by master 1.
    drive(1'b1, 4'b0010, 4'b0000, 2'b00, 3'd0, 1'b1, 1'b0);
    check("incr4_start", 32'(hgrant), 32'h2);
    drive(1'b1, 4'b0011, 4'b0000, 2'b10, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 4'b0011, 4'b0000, 2'b11, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 4'b0011, 4'b0000, 2'b11, 3'd3, 1'b1, 1'b0);
    check("incr4_hold", 32'(hgrant), 32'h2);
    drive(1'b1, 4'b0011, 4'b0000, 2'b11, 3'd3, 1'b1, 1'b0);
    check("incr4_handover", 32'(hgrant), 32'h1);

    // Same burst with a two-cycle stall inside.
    drive(1'b1, 4'b0010, 4'b0000, 2'b00, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 4'b0011, 4'b0000, 2'b10, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 4'b0011, 4'b0000, 2'b11, 3'd3, 1'b1, 1'b0);
    drive(1'b1, 4'b0011, 4'b0000, 2'b11, 3'd3, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 4'b0000, 2'b11, 3'd3, 1'b0, 1'b0);
    check("stall_hold", 32'({hgrant, hmaster}), 32'({4'b0010, 2'd1}));
    drive(1'b1, 4'b0011, 4'b0000, 2'b11, 3'd3, 1'b1, 1'b0);
    check("stall_still_held", 32'(hgrant), 32'h2);
    drive(1'b1, 4'b0011, 4'b0000, 2'b11, 3'd3, 1'b1, 1'b0);
    check("stall_handover", 32'(hgrant), 32'h1);

    // Locked sequence by master 2, then release.
    drive(1'b1, 4'b0100, 4'b0100, 2'b00, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1111, 4'b0100, 2'b10, 3'd0, 1'b1, 1'b0);
      check("lock_grant", 32'(hgrant), 32'h4);
    end
    check("lock_mastlock", 32'(hmastlock), 32'h1);
    drive(1'b1, 4'b1111, 4'b0000, 2'b10, 3'd0, 1'b1, 1'b0);
    check("lock_release", 32'(hgrant), 32'h8);

    // Parking, then INCR8 cut short by an ERROR response.
    drive(1'b1, 4'b0000, 4'b0000, 2'b00, 3'd0, 1'b1, 1'b0);
    check("park_default", 32'(hgrant), 32'h1);
    drive(1'b1, 4'b0110, 4'b0000, 2'b00, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 4'b0110, 4'b0000, 2'b10, 3'd5, 1'b1, 1'b0);
    drive(1'b1, 4'b0110, 4'b0000, 2'b11, 3'd5, 1'b1, 1'b0);
    drive(1'b1, 4'b0110, 4'b0000, 2'b11, 3'd5, 1'b1, 1'b1);
    check("error_handover", 32'(hgrant), 32'h4);

    // Reset in the middle of INCR16.
    drive(1'b1, 4'b1000, 4'b0000, 2'b00, 3'd0, 1'b1, 1'b0);
    drive(1'b1, 4'b1000, 4'b0000, 2'b10, 3'd7, 1'b1, 1'b0);
    drive(1'b1, 4'b1000, 4'b0000, 2'b11, 3'd7, 1'b1, 1'b0);
    drive(1'b0, 4'b1000, 4'b1000, 2'b11, 3'd7, 1'b1, 1'b0);
    check("reset_mid_burst", 32'({hgrant, hmaster, hmastlock}), 32'({4'b0001, 2'd0, 1'b0}));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0),
            4'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
            2'($urandom),
            3'($urandom),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
